// File: rtl/wch_sequencer_pkg.sv
// Shared definitions for the weight-change sequencer: default sizes and FSM state encoding.
package wch_sequencer_pkg;

  localparam int unsigned N1 = 784;
  localparam int unsigned WD = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_SWEEP = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } wch_state_e;

endpackage

// File: rtl/wch_sequencer_sweep_counter.sv
// ip_select sweep counter: synchronous clear, count enable, registered terminal flag at N_IN-1.
module wch_sweep_counter #(
  parameter int unsigned N_IN = 784,
  parameter int unsigned AW   = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [AW-1:0] cnt_o,
  output logic          term_o
);

  logic [AW-1:0] cnt_q, cnt_d;
  logic          term_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + AW'(1);
    end
  end

  // Terminal flag tracks the next count so it is valid in the same cycle as cnt_o.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      term_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= (cnt_d == AW'(N_IN - 1));
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = term_q;

endmodule

// File: rtl/wch_sequencer.sv
// Walks the layer's output neurons on a learn request and drives the weight-change engine
// handshake (start, direction, steps, bank select, input sweep) for each enabled neuron.
module wch_sequencer
  import wch_sequencer_pkg::*;
#(
  parameter int unsigned N_IN  = N1,
  parameter int unsigned N_OUT = 8,
  parameter int unsigned W     = WD,
  parameter int unsigned AW    = 10,
  parameter int unsigned NW    = 3,
  parameter int unsigned TMO   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             learn_req,
  input  logic [N_OUT-1:0] post_spike,
  input  logic [N_OUT-1:0] learn_mask,
  input  logic [W-1:0]     del_plus_cfg,
  input  logic [W-1:0]     del_minus_cfg,
  input  logic             valid_wch,
  output logic             start_wch,
  output logic             spike_hold,
  output logic [AW-1:0]    ip_select,
  output logic [W-1:0]     del_w_plus,
  output logic [W-1:0]     del_w_minus,
  output logic [NW-1:0]    wsel,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned NIW = NW + 1;
  localparam int unsigned TW  = $clog2(N_IN + TMO);

  wch_state_e       state_q, state_d;
  logic [NIW-1:0]   nidx_q, nidx_d;
  logic [N_OUT-1:0] post_q, post_d;
  logic [N_OUT-1:0] mask_q, mask_d;
  logic [W-1:0]     dplus_q, dplus_d;
  logic [W-1:0]     dminus_q, dminus_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             start_q, start_d;
  logic             hold_q, hold_d;
  logic [NW-1:0]    wsel_q, wsel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cnt_clr, cnt_en, cnt_term;

  wch_sweep_counter #(
    .N_IN (N_IN),
    .AW   (AW)
  ) u_sweep (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (ip_select),
    .term_o (cnt_term)
  );

  always_comb begin
    state_d  = state_q;
    nidx_d   = nidx_q;
    post_d   = post_q;
    mask_d   = mask_q;
    dplus_d  = dplus_q;
    dminus_d = dminus_q;
    tmo_d    = tmo_q;
    start_d  = 1'b0;
    hold_d   = hold_q;
    wsel_d   = wsel_q;
    done_d   = 1'b0;
    err_d    = err_q;
    cnt_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (learn_req) begin
          post_d   = post_spike;
          mask_d   = learn_mask;
          dplus_d  = del_plus_cfg;
          dminus_d = del_minus_cfg;
          nidx_d   = '0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (nidx_q == NIW'(N_OUT)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (!mask_q[nidx_q[NW-1:0]]) begin
          nidx_d = nidx_q + NIW'(1);
        end else begin
          state_d = ST_SWEEP;
          start_d = 1'b1;
          hold_d  = post_q[nidx_q[NW-1:0]];
          wsel_d  = nidx_q[NW-1:0];
          tmo_d   = '0;
        end
      end
      ST_SWEEP: begin
        tmo_d = tmo_q + TW'(1);
        if (cnt_term) begin
          state_d = ST_WAIT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_WAIT: begin
        // A completion arriving on the last timeout cycle still wins.
        if (valid_wch) begin
          nidx_d  = nidx_q + NIW'(1);
          state_d = ST_SCAN;
        end else if (tmo_q == TW'(N_IN + TMO - 1)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (learn_req && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end
    cnt_clr = start_d || (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      nidx_q   <= '0;
      post_q   <= '0;
      mask_q   <= '0;
      dplus_q  <= '0;
      dminus_q <= '0;
      tmo_q    <= '0;
      start_q  <= 1'b0;
      hold_q   <= 1'b0;
      wsel_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      nidx_q   <= nidx_d;
      post_q   <= post_d;
      mask_q   <= mask_d;
      dplus_q  <= dplus_d;
      dminus_q <= dminus_d;
      tmo_q    <= tmo_d;
      start_q  <= start_d;
      hold_q   <= hold_d;
      wsel_q   <= wsel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign start_wch   = start_q;
  assign spike_hold  = hold_q;
  assign del_w_plus  = dplus_q;
  assign del_w_minus = dminus_q;
  assign wsel        = wsel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_wch_sequencer.sv
// Bench for wch_sequencer: a pass-level timing model builds the expected per-cycle output trace,
// then the stimulus is replayed and every output is compared each cycle.
module tb_wch_sequencer;

  localparam int N_IN  = 8;
  localparam int N_OUT = 4;
  localparam int W     = 24;
  localparam int AW    = 10;
  localparam int NW    = 2;
  localparam int TMO   = 16;
  localparam int MAXC  = 8192;

  logic             clk;
  logic             rst;
  logic             learn_req;
  logic [N_OUT-1:0] post_spike;
  logic [N_OUT-1:0] learn_mask;
  logic [W-1:0]     del_plus_cfg;
  logic [W-1:0]     del_minus_cfg;
  logic             valid_wch;
  logic             start_wch;
  logic             spike_hold;
  logic [AW-1:0]    ip_select;
  logic [W-1:0]     del_w_plus;
  logic [W-1:0]     del_w_minus;
  logic [NW-1:0]    wsel;
  logic             busy;
  logic             done;
  logic             err;

  wch_sequencer #(
    .N_IN (N_IN), .N_OUT (N_OUT), .W (W), .AW (AW), .NW (NW), .TMO (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .learn_req     (learn_req),
    .post_spike    (post_spike),
    .learn_mask    (learn_mask),
    .del_plus_cfg  (del_plus_cfg),
    .del_minus_cfg (del_minus_cfg),
    .valid_wch     (valid_wch),
    .start_wch     (start_wch),
    .spike_hold    (spike_hold),
    .ip_select     (ip_select),
    .del_w_plus    (del_w_plus),
    .del_w_minus   (del_w_minus),
    .wsel          (wsel),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus per edge number
  bit               in_rst   [MAXC];
  bit               in_learn [MAXC];
  bit               in_valid [MAXC];
  bit               in_set   [MAXC];
  logic [N_OUT-1:0] in_post  [MAXC];
  logic [N_OUT-1:0] in_mask  [MAXC];
  logic [W-1:0]     in_dp    [MAXC];
  logic [W-1:0]     in_dm    [MAXC];

  // Expected outputs visible just after each edge
  bit               exp_start [MAXC];
  bit               exp_done  [MAXC];
  bit               exp_busy  [MAXC];
  bit               exp_err   [MAXC];
  bit               exp_hold  [MAXC];
  int               exp_ip    [MAXC];
  int               exp_wsel  [MAXC];
  logic [W-1:0]     exp_dp    [MAXC];
  logic [W-1:0]     exp_dm    [MAXC];

  int           m_ip   = 0;
  int           m_wsel = 0;
  bit           m_hold = 1'b0;
  bit           m_busy = 1'b0;
  bit           m_err  = 1'b0;
  logic [W-1:0] m_dp   = '0;
  logic [W-1:0] m_dm   = '0;
  int           lf     = 0;

  int n_chk = 0;
  int n_bad = 0;
  int cur_t = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", tag, cur_t, got, want);
    end
  endtask

  function automatic void put(input int t, input bit st, input bit dn);
    exp_start[t] = st;
    exp_done[t]  = dn;
    exp_busy[t]  = m_busy;
    exp_err[t]   = m_err;
    exp_ip[t]    = m_ip;
    exp_wsel[t]  = m_wsel;
    exp_hold[t]  = m_hold;
    exp_dp[t]    = m_dp;
    exp_dm[t]    = m_dm;
  endfunction

  function automatic void hold_until(input int te);
    while (lf < te) begin
      lf++;
      put(lf, 1'b0, 1'b0);
    end
  endfunction

  // One learning pass from a request sampled at edge k. dly[n]=0 means the engine never answers;
  // rst_off>0 pulls reset that many edges after the first start (inside WAIT).
  task automatic plan_pass(input logic [N_OUT-1:0] mask, input logic [N_OUT-1:0] post,
                           input logic [W-1:0] dp, input logic [W-1:0] dm,
                           input int dly [N_OUT], input int rst_off, input int gap,
                           input int k, output int d_edge);
    int cur;
    int s;
    bit hit;
    hold_until(k - 1);
    in_learn[k] = 1'b1;
    in_set[k]   = 1'b1;
    in_mask[k]  = mask;
    in_post[k]  = post;
    in_dp[k]    = dp;
    in_dm[k]    = dm;
    m_busy = 1'b1;
    m_dp   = dp;
    m_dm   = dm;
    lf     = k;
    put(k, 1'b0, 1'b0);
    cur = k;
    hit = 1'b0;
    for (int n = 0; n < N_OUT; n++) begin
      if (!hit) begin
        if (!mask[n]) begin
          cur++;
        end else begin
          s = cur + 1;
          hold_until(s - 1);
          m_ip   = 0;
          m_wsel = n;
          m_hold = post[n];
          lf     = s;
          put(s, 1'b1, 1'b0);
          for (int j = 1; j < N_IN; j++) begin
            m_ip = j;
            lf++;
            put(lf, 1'b0, 1'b0);
          end
          if ($urandom_range(0, 1) == 1) in_valid[s + int'($urandom_range(1, N_IN))] = 1'b1;
          if (rst_off > 0) begin
            hold_until(s + rst_off - 1);
            m_ip = 0; m_wsel = 0; m_hold = 1'b0; m_busy = 1'b0; m_err = 1'b0;
            m_dp = '0; m_dm = '0;
            in_rst[s + rst_off] = 1'b1;
            lf = s + rst_off;
            put(lf, 1'b0, 1'b0);
            hit = 1'b1;
          end else if (dly[n] > 0) begin
            in_valid[s + dly[n]] = 1'b1;
            cur = s + dly[n];
            hold_until(cur);
          end else begin
            hold_until(s + N_IN + TMO - 1);
            m_err = 1'b1;
            lf = s + N_IN + TMO;
            put(lf, 1'b0, 1'b1);
            hit = 1'b1;
          end
        end
      end
    end
    if (!hit) begin
      hold_until(cur);
      lf = cur + 1;
      put(lf, 1'b0, 1'b1);
    end
    d_edge = lf;
    m_busy = 1'b0;
    m_ip   = 0;
    hold_until(lf + gap);
    if ($urandom_range(0, 1) == 1) in_valid[d_edge + 1 + int'($urandom_range(0, gap - 1))] = 1'b1;
  endtask

  // Request while busy: ignored, but err goes sticky from that edge on.
  function automatic void apply_ovr(input int e);
    in_learn[e] = 1'b1;
    for (int t = e; t <= lf; t++) exp_err[t] = 1'b1;
    m_err = 1'b1;
  endfunction

  initial begin
    int k;
    int d;
    int ks;
    int dly [N_OUT];
    logic [N_OUT-1:0] rmask;

    in_rst[1] = 1'b1;
    in_rst[2] = 1'b1;
    hold_until(2);
    k = 4;

    dly = '{N_IN + 6, N_IN + 6, N_IN + 6, N_IN + 6};
    plan_pass(4'b1111, 4'b0101, 24'h000400, 24'h000400, dly, 0, 2, k, d);
    k = lf + 1;
    dly = '{0, 0, N_IN + 1, 0};
    plan_pass(4'b0100, 4'b1011, 24'h123456, 24'h00abcd, dly, 0, 3, k, d);
    k = lf + 1;
    plan_pass(4'b0000, 4'b1111, 24'h000001, 24'hfffffe, dly, 0, 2, k, d);
    k = lf + 1;
    dly = '{N_IN + TMO, N_IN + TMO, N_IN + TMO, N_IN + TMO};
    plan_pass(4'b1001, 4'b0001, 24'h000200, 24'h000300, dly, 0, 3, k, d);
    apply_ovr(d + 1);
    k = lf + 1;
    plan_pass(4'b1111, 4'b1100, 24'h000011, 24'h000022, dly, N_IN + 3, 2, k, d);
    k = lf + 1;
    ks = k;
    dly = '{N_IN + 2, N_IN + 4, N_IN + 3, N_IN + 5};
    plan_pass(4'b1011, 4'b0110, 24'h0a0a0a, 24'h050505, dly, 0, 2, k, d);
    apply_ovr(ks + 4);
    k = lf + 1;
    plan_pass(4'b0001, 4'b0001, 24'h000033, 24'h000044, dly, N_IN + 1, 2, k, d);
    k = lf + 1;
    dly = '{N_IN + 5, 0, N_IN + 5, N_IN + 5};
    plan_pass(4'b1111, 4'b1010, 24'h000777, 24'h000888, dly, 0, 3, k, d);
    k = lf + 1;
    plan_pass(4'b0010, 4'b0010, 24'h000001, 24'h000002, dly, N_IN + TMO - 1, 2, k, d);
    k = lf + 1;

    for (int p = 0; p < 18; p++) begin
      int roff;
      for (int n = 0; n < N_OUT; n++)
        dly[n] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(N_IN + 1, N_IN + TMO));
      rmask = N_OUT'($urandom);
      roff  = ($urandom_range(0, 6) == 0) ? int'($urandom_range(N_IN + 1, N_IN + TMO)) : 0;
      ks = k;
      plan_pass(rmask, N_OUT'($urandom), W'($urandom), W'($urandom), dly, roff,
                int'($urandom_range(1, 4)), k, d);
      if (roff == 0 && $urandom_range(0, 3) == 0)
        apply_ovr(ks + 1 + int'($urandom_range(0, d - ks)));
      k = lf + 1;
    end

    for (int t = 1; t <= lf; t++) begin
      rst       = in_rst[t] ? 1'b0 : 1'b1;
      learn_req = in_learn[t];
      valid_wch = in_valid[t];
      if (in_set[t]) begin
        post_spike    = in_post[t];
        learn_mask    = in_mask[t];
        del_plus_cfg  = in_dp[t];
        del_minus_cfg = in_dm[t];
      end else begin
        post_spike    = N_OUT'($urandom);
        learn_mask    = N_OUT'($urandom);
        del_plus_cfg  = W'($urandom);
        del_minus_cfg = W'($urandom);
      end
      @(posedge clk);
      #1;
      cur_t = t;
      chk("start",  32'(start_wch),   32'(exp_start[t]));
      chk("done",   32'(done),        32'(exp_done[t]));
      chk("busy",   32'(busy),        32'(exp_busy[t]));
      chk("err",    32'(err),         32'(exp_err[t]));
      chk("ip",     32'(ip_select),   32'(exp_ip[t]));
      chk("wsel",   32'(wsel),        32'(exp_wsel[t]));
      chk("hold",   32'(spike_hold),  32'(exp_hold[t]));
      chk("dplus",  32'(del_w_plus),  32'(exp_dp[t]));
      chk("dminus", 32'(del_w_minus), 32'(exp_dm[t]));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
